// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - Two-flop synchronizer plus stability-qualified debounce FSM
//
// Turns a raw, bouncing, asynchronous button/switch level into a clean
// Clk-synchronous level with one-cycle Rise/Fall pulses.
//
// Build option: define DEBOUNCE_ACTIVE_LOW_EN for active-low (pull-up) buttons;
// Btn is then inverted ahead of the synchronizer so Debounced = 1 means pressed.
//
// Parameters:
//   STABLE_COUNT  consecutive synchronized samples required to accept a level
//                 change (legal 2..2^24)
//
// Ports:
//   Clk        in   system clock, all state updates on posedge
//   Reset      in   asynchronous active-high reset, clears all state
//   Btn        in   raw button level, asynchronous to Clk
//   Debounced  out  registered qualified level
//   Rise       out  one-Clk pulse when Debounced goes 0->1
//   Fall       out  one-Clk pulse when Debounced goes 1->0

`timescale 1ns/1ps

module button_debouncer #(
    parameter int STABLE_COUNT = 1000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Btn,
    output logic Debounced,
    output logic Rise,
    output logic Fall
);

    localparam int CNT_W = $clog2(STABLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             deb_nx, rise_nx, fall_nx;
    logic             btn_in;
    logic             sync1, sync2;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
    assign btn_in = ~Btn;
`else
    assign btn_in = Btn;
`endif

    // Metastability guard: only sync2 is ever looked at by the FSM.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            Debounced <= 1'b0;
            Rise      <= 1'b0;
            Fall      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            Debounced <= deb_nx;
            Rise      <= rise_nx;
            Fall      <= fall_nx;
        end
    end

    // cnt holds how many consecutive opposite-level samples have been seen;
    // the sample that makes it STABLE_COUNT is the one that commits.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        deb_nx   = Debounced;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (sync2) begin
                    state_nx = WAIT_HIGH;
                    cnt_nx   = CNT_ONE;
                end else begin
                    cnt_nx = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync2) begin
                    state_nx = IDLE_LOW;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE_HIGH;
                    deb_nx   = 1'b1;
                    rise_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync2) begin
                    state_nx = WAIT_LOW;
                    cnt_nx   = CNT_ONE;
                end else begin
                    cnt_nx = '0;
                end
            end
            WAIT_LOW: begin
                if (sync2) begin
                    state_nx = IDLE_HIGH;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE_LOW;
                    deb_nx   = 1'b0;
                    fall_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = IDLE_LOW;
                cnt_nx   = '0;
                deb_nx   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - Directed and randomized check of button_debouncer against a run-length model

`timescale 1ns/1ps

module tb_button_debouncer;

    localparam int N = 4;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
    localparam logic PRESS = 1'b0;
`else
    localparam logic PRESS = 1'b1;
`endif

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Btn = ~PRESS;
    logic Debounced, Rise, Fall;

    int n_checks = 0;
    int n_pass   = 0;

    button_debouncer #(.STABLE_COUNT(N)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Btn       (Btn),
        .Debounced (Debounced),
        .Rise      (Rise),
        .Fall      (Fall)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: the FSM at each edge sees the pressed-level sample
    // taken two edges earlier. Debounced flips when N consecutive samples
    // disagree with it; any agreeing sample clears the run.
    logic pipe [0:1];
    logic m_deb, m_rise, m_fall;
    int   run;

    always @(posedge Clk or posedge Reset) begin
        logic s;
        if (Reset) begin
            pipe[0] = 1'b0; pipe[1] = 1'b0;
            m_deb = 1'b0; m_rise = 1'b0; m_fall = 1'b0; run = 0;
        end else begin
            s = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (Btn == PRESS);
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (s != m_deb) begin
                run++;
                if (run == N) begin
                    m_deb = s;
                    run = 0;
                    if (s) m_rise = 1'b1;
                    else   m_fall = 1'b1;
                end
            end else begin
                run = 0;
            end
        end
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            check("model_deb",  Debounced, m_deb);
            check("model_rise", Rise,      m_rise);
            check("model_fall", Fall,      m_fall);
        end
    end

    initial begin
        int nr, nf, len, r;
        logic [9:0] pat;

        repeat (3) @(posedge Clk);
        #1;
        check("rst_deb",  Debounced, 0);
        check("rst_rise", Rise, 0);
        check("rst_fall", Fall, 0);
        @(negedge Clk) Reset = 1'b0;
        repeat (3) @(negedge Clk);

        // Steady press: latency N+2 edges
        Btn = PRESS;
        repeat (5) @(posedge Clk);
        #1;
        check("t1_e5_deb",  Debounced, 0);
        check("t1_e5_rise", Rise, 0);
        @(posedge Clk); #1;
        check("t1_e6_deb",  Debounced, 1);
        check("t1_e6_rise", Rise, 1);
        check("t1_e6_fall", Fall, 0);
        @(posedge Clk); #1;
        check("t1_e7_rise", Rise, 0);
        check("t1_e7_deb",  Debounced, 1);

        // Short release glitch is rejected
        @(negedge Clk) Btn = ~PRESS;
        repeat (3) @(negedge Clk);
        Btn = PRESS;
        nf = 0;
        repeat (12) begin
            @(posedge Clk); #1;
            if (Fall) nf++;
        end
        check("t2_falls", nf, 0);
        check("t2_deb",   Debounced, 1);

        // Held release: Fall at edge 6
        @(negedge Clk) Btn = ~PRESS;
        repeat (5) @(posedge Clk);
        #1;
        check("t4_e5_deb", Debounced, 1);
        @(posedge Clk); #1;
        check("t4_e6_deb",  Debounced, 0);
        check("t4_e6_fall", Fall, 1);
        check("t4_e6_rise", Rise, 0);
        repeat (4) @(negedge Clk);

        // Bounce pattern then steady press
        pat = 10'b1011011111;
        nr = 0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge Clk);
            Btn = pat[i] ? PRESS : ~PRESS;
            if (Rise) nr++;
        end
        repeat (12) begin
            @(negedge Clk);
            if (Rise) nr++;
        end
        check("t3_rises", nr, 1);
        check("t3_deb",   Debounced, 1);

        // Back to released, then reset mid WAIT_HIGH (cnt = 2)
        @(negedge Clk) Btn = ~PRESS;
        repeat (10) @(negedge Clk);
        Btn = PRESS;
        repeat (4) @(posedge Clk);
        #3 Reset = 1'b1;
        #1;
        check("t5_rst_deb",  Debounced, 0);
        check("t5_rst_rise", Rise, 0);
        check("t5_rst_fall", Fall, 0);
        @(negedge Clk) Reset = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        check("t5_e5_rise", Rise, 0);
        @(posedge Clk); #1;
        check("t5_e6_rise", Rise, 1);
        check("t5_e6_deb",  Debounced, 1);

        // Reset while in IDLE_HIGH drops Debounced at once, no Fall
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("t7_rst_deb",  Debounced, 0);
        check("t7_rst_fall", Fall, 0);
        @(negedge Clk) begin Reset = 1'b0; Btn = ~PRESS; end
        repeat (4) @(negedge Clk);

        // Randomized segments with occasional asynchronous resets
        for (int seg = 0; seg < 250; seg++) begin
            Btn = $urandom_range(0, 1) ? PRESS : ~PRESS;
            len = $urandom_range(1, 7);
            repeat (len) @(negedge Clk);
            if ($urandom_range(0, 39) == 0) begin
                @(posedge Clk);
                r = $urandom_range(1, 4);
                #(r) Reset = 1'b1;
                #1;
                check("rnd_rst_deb", Debounced, 0);
                @(negedge Clk) Reset = 1'b0;
            end
        end
        repeat (10) @(negedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
